snake_head_mover: RTL and testbench
===================================

# snake_head_mover

Consumes the one-hot `direction` word produced by the button-side direction generator and turns it into snake head motion on the playfield grid. A prescaler produces the game tick; on each tick the block samples `direction`, rejects illegal or reversing requests, advances the head one cell, and detects wall collisions. Its outputs feed the body/trail logic and the VGA renderer.

## Interface
- `GRID_W`, 40: playfield width in cells; legal x is 0..GRID_W-1
- `GRID_H`, 30: playfield height in cells; legal y is 0..GRID_H-1
- `X_W`, 6: width of `head_x`
- `Y_W`, 5: width of `head_y`
- `START_X`, 20: head x after reset/restart
- `START_Y`, 15: head y after reset/restart
- `TICK_DIV`, 12_500_000: clk cycles per game tick; minimum 2
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `direction`  in  4  one-hot request: 4'b1000 up, 4'b0100 down, 4'b0010 left, 4'b0001 right
- `enable`  in  1  level; 1 = game running, 0 = paused
- `restart`  in  1  synchronous one-cycle request to return to start
- `head_x`  out  X_W  current head column
- `head_y`  out  Y_W  current head row (0 = top)
- `move_dir`  out  4  direction applied on the last move (one-hot)
- `step`  out  1  one-cycle pulse, head moved this tick
- `dead`  out  1  level, wall collision occurred
- `running`  out  1  level, state == RUN

## Operation
- States: IDLE, RUN, DEAD.
- Reset values: state IDLE; head_x = START_X; head_y = START_Y; move_dir = 4'b0100; step = 0; dead = 0; running = 0; tick counter = 0.
- IDLE: head held at start. `enable` = 1 -> RUN with counter cleared.
- RUN: counter increments while `enable` = 1 and holds (does not clear) while `enable` = 0. At counter == TICK_DIV-1 (the tick cycle), counter -> 0 and a move is evaluated.
- Direction selection at tick: new_dir = `direction` if it is exactly one-hot and not the opposite of `move_dir` (up/down, left/right pairs); otherwise new_dir = `move_dir`. This guard catches two rapid turns between ticks that would reverse the snake.
- Next position: up y-1, down y+1, left x-1, right x+1. Bounds are checked before the register update, using a width one bit wider than the coordinate so x = 0 going left and y = 0 going up are detected without wrap.
- In bounds: head <= next, move_dir <= new_dir, step = 1 for one cycle.
- Out of bounds: head and move_dir unchanged, no step, state -> DEAD, dead = 1.
- DEAD: all outputs frozen; only `restart` leaves.
- `restart` = 1 in any state: next cycle state IDLE, head = start, move_dir = 4'b0100, counter = 0, dead = 0, step = 0. `restart` takes priority over a coincident tick.

## Timing
- Outputs are registered. The head value, `move_dir` and `step` become visible on the clock after the tick cycle.
- First move happens TICK_DIV cycles after entering RUN, provided `enable` stays 1.
- `direction` is sampled only in the tick cycle. Changes between ticks are ignored except for the last value present at the tick.
- `dead` asserts one cycle after the tick cycle and stays high until restart.
- Asynchronous `rst_n` mid-move aborts the move; all outputs take their reset values immediately.

## Structure
- Shared package `snake_pkg` holds:
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT one-hot constants
  - a state enum
  - default GRID_W/GRID_H, also used by the direction generator and the renderer
- One natural sub-module is `tick_gen`: a prescaler with `en` and synchronous `clr`, producing a one-cycle `tick`.
- The direction guard and the next-position/bounds logic are combinational inside the top.

## Test plan
- Bench uses TICK_DIV = 4. Reset, `enable` = 1, `direction` = 4'b0100: `step` pulses every 4 cycles; y goes 15 -> 16 -> 17; x stays 20.
- From down, `direction` = 4'b1000 (reversal) at the tick: move is ignored as a direction change; y keeps incrementing; `move_dir` stays 4'b0100.
- Set `direction` = 4'b0011 or 4'b0000 at a tick: `move_dir` is retained and the head advances in the old direction.
- Set START_X = 1, move left: x goes 1 -> 0. On the next tick, `dead` = 1, x stays 0, no `step`, and later ticks cause no motion.
- Drop `enable` for 10 cycles mid-count: the counter holds and the next `step` is delayed by exactly 10 cycles.
- `restart` in DEAD, and `restart` coincident with a tick in RUN: both return to IDLE at (20,15) with `move_dir` 4'b0100 and `dead` = 0. Asserting `rst_n` = 0 mid-RUN gives the same values asynchronously.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game definitions: direction encodings, FSM states and
// default playfield size used by the mover, direction generator and renderer.
package snake_pkg;

  localparam int DEF_GRID_W = 40;
  localparam int DEF_GRID_H = 30;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Up<->down and left<->right swapped.
  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  function automatic logic dir_onehot(input logic [3:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

endpackage

// File: rtl/snake_head_mover_tick_gen.sv
// Game-tick prescaler: counts enabled cycles and emits a one-cycle tick
// every TICK_DIV of them; holds while disabled, synchronous clear.
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = en && (cnt_r == CNT_LAST);

  // Prescaler counter: clear wins, wrap on tick, hold while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/snake_head_mover.sv
// Snake head motion: on each game tick applies the guarded direction request,
// moves the head one cell and stops in DEAD on a wall collision.
module snake_head_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     direction,
  input  logic           enable,
  input  logic           restart,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [3:0]     move_dir,
  output logic           step,
  output logic           dead,
  output logic           running
);

  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
  localparam logic [X_W:0]   X_LIM   = (X_W + 1)'(GRID_W);
  localparam logic [Y_W:0]   Y_LIM   = (Y_W + 1)'(GRID_H);
  localparam logic [X_W:0]   X_ONE   = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0]   Y_ONE   = {{Y_W{1'b0}}, 1'b1};

  state_e         state_r, state_nxt_s;
  logic [X_W-1:0] head_x_r, x_nxt_s;
  logic [Y_W-1:0] head_y_r, y_nxt_s;
  logic [3:0]     move_dir_r, dir_nxt_s, new_dir_s;
  logic           step_r, step_nxt_s;
  logic           dead_r, running_r;
  logic [X_W:0]   x_try_s;
  logic [Y_W:0]   y_try_s;
  logic           oob_s;
  logic           tick_s, cnt_en_s, cnt_clr_s;

  assign cnt_en_s  = (state_r == ST_RUN) && enable;
  assign cnt_clr_s = restart || (state_r != ST_RUN);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en_s),
    .clr  (cnt_clr_s),
    .tick (tick_s)
  );

  // Direction guard and candidate position, one bit wider so 0-1 cannot wrap into range.
  always_comb begin
    if (dir_onehot(direction) && (direction != dir_opposite(move_dir_r))) begin
      new_dir_s = direction;
    end else begin
      new_dir_s = move_dir_r;
    end
    x_try_s = {1'b0, head_x_r};
    y_try_s = {1'b0, head_y_r};
    case (new_dir_s)
      DIR_UP:    y_try_s = {1'b0, head_y_r} - Y_ONE;
      DIR_DOWN:  y_try_s = {1'b0, head_y_r} + Y_ONE;
      DIR_LEFT:  x_try_s = {1'b0, head_x_r} - X_ONE;
      DIR_RIGHT: x_try_s = {1'b0, head_x_r} + X_ONE;
      default: begin
        x_try_s = {1'b0, head_x_r};
        y_try_s = {1'b0, head_y_r};
      end
    endcase
    oob_s = (x_try_s >= X_LIM) || (y_try_s >= Y_LIM);
  end

  // FSM next state and next output values; restart overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = head_x_r;
    y_nxt_s     = head_y_r;
    dir_nxt_s   = move_dir_r;
    step_nxt_s  = 1'b0;
    if (restart) begin
      state_nxt_s = ST_IDLE;
      x_nxt_s     = X_START;
      y_nxt_s     = Y_START;
      dir_nxt_s   = DIR_DOWN;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tick_s && oob_s) begin
            state_nxt_s = ST_DEAD;
          end else if (tick_s) begin
            x_nxt_s    = x_try_s[X_W-1:0];
            y_nxt_s    = y_try_s[Y_W-1:0];
            dir_nxt_s  = new_dir_s;
            step_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DEAD: state_nxt_s = ST_DEAD;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      head_x_r   <= X_START;
      head_y_r   <= Y_START;
      move_dir_r <= DIR_DOWN;
      step_r     <= 1'b0;
      dead_r     <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      head_x_r   <= x_nxt_s;
      head_y_r   <= y_nxt_s;
      move_dir_r <= dir_nxt_s;
      step_r     <= step_nxt_s;
      dead_r     <= (state_nxt_s == ST_DEAD);
      running_r  <= (state_nxt_s == ST_RUN);
    end
  end

  assign head_x   = head_x_r;
  assign head_y   = head_y_r;
  assign move_dir = move_dir_r;
  assign step     = step_r;
  assign dead     = dead_r;
  assign running  = running_r;

endmodule

// File: tb/tb_snake_head_mover.sv
// Scoreboard bench for snake_head_mover: expected moves are queued with the
// cycle they must appear in; monitors pop and compare on every step pulse.
module tb_snake_head_mover;
  import snake_pkg::*;

  typedef struct {
    int cyc;
    int x;
    int y;
    int dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, b_rst_n;
  logic [3:0] direction, b_direction;
  logic       enable, b_enable, restart, b_restart;
  logic [5:0] head_x, b_head_x;
  logic [4:0] head_y, b_head_y;
  logic [3:0] move_dir, b_move_dir;
  logic       step, b_step, dead, b_dead, running, b_running;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   p, q;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snake_head_mover #(.TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .direction(direction), .enable(enable),
    .restart(restart), .head_x(head_x), .head_y(head_y), .move_dir(move_dir),
    .step(step), .dead(dead), .running(running)
  );

  snake_head_mover #(.TICK_DIV(4), .START_X(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .direction(b_direction), .enable(b_enable),
    .restart(b_restart), .head_x(b_head_x), .head_y(b_head_y), .move_dir(b_move_dir),
    .step(b_step), .dead(b_dead), .running(b_running)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_a(input int c, input int x, input int y, input int d);
    exp_t e;
    e.cyc = c; e.x = x; e.y = y; e.dir = d;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input int x, input int y, input int d);
    exp_t e;
    e.cyc = c; e.x = x; e.y = y; e.dir = d;
    qb.push_back(e);
  endtask

  // Monitor for dut_a: every step must match the oldest queued move.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_step_cycle", cyc, e.cyc);
        check("a_head_x", int'(head_x), e.x);
        check("a_head_y", int'(head_y), e.y);
        check("a_move_dir", int'(move_dir), e.dir);
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (b_step === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_step_cycle", cyc, e.cyc);
        check("b_head_x", int'(b_head_x), e.x);
        check("b_head_y", int'(b_head_y), e.y);
        check("b_move_dir", int'(b_move_dir), e.dir);
      end
    end
  end

  initial begin
    rst_n = 1'b0; b_rst_n = 1'b0;
    enable = 1'b0; b_enable = 1'b0;
    restart = 1'b0; b_restart = 1'b0;
    direction = DIR_DOWN; b_direction = DIR_LEFT;
    repeat (3) @(negedge clk);
    check("rst_x", int'(head_x), 20);
    check("rst_y", int'(head_y), 15);
    check("rst_dir", int'(move_dir), 4);
    check("rst_step", int'(step), 0);
    check("rst_dead", int'(dead), 0);
    check("rst_running", int'(running), 0);
    check("b_rst_x", int'(b_head_x), 1);
    rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold_running", int'(running), 0);

    // dut_a: straight down, then rejected and illegal requests
    p = cyc;
    enable = 1'b1;
    push_a(p + 5, 20, 16, 4);
    push_a(p + 9, 20, 17, 4);
    wait_until(p + 1);
    check("run_entered", int'(running), 1);
    wait_until(p + 12); direction = DIR_UP;
    push_a(p + 13, 20, 18, 4);
    wait_until(p + 16); direction = 4'b0011;
    push_a(p + 17, 20, 19, 4);
    wait_until(p + 20); direction = 4'b0000;
    push_a(p + 21, 20, 20, 4);
    // only the value present in the tick cycle counts
    wait_until(p + 22); direction = DIR_UP;
    wait_until(p + 23); direction = DIR_LEFT;
    wait_until(p + 24); direction = DIR_RIGHT;
    push_a(p + 25, 21, 20, 1);
    wait_until(p + 28); direction = DIR_LEFT;
    push_a(p + 29, 22, 20, 1);
    wait_until(p + 32); direction = DIR_UP;
    push_a(p + 33, 22, 19, 8);

    // pause for 10 cycles mid-count
    wait_until(p + 34); enable = 1'b0;
    wait_until(p + 40);
    check("pause_running", int'(running), 1);
    wait_until(p + 44); enable = 1'b1;
    push_a(p + 47, 22, 18, 8);

    // restart coincident with the tick
    wait_until(p + 50); restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_tick_step", int'(step), 0);
    check("rs_tick_x", int'(head_x), 20);
    check("rs_tick_y", int'(head_y), 15);
    check("rs_tick_dir", int'(move_dir), 4);
    check("rs_tick_dead", int'(dead), 0);
    check("rs_tick_running", int'(running), 0);
    push_a(p + 56, 20, 16, 4);
    wait_until(p + 52);
    check("rerun_running", int'(running), 1);

    // asynchronous reset mid-run
    wait_until(p + 58);
    rst_n = 1'b0;
    #1;
    check("async_x", int'(head_x), 20);
    check("async_y", int'(head_y), 15);
    check("async_dir", int'(move_dir), 4);
    check("async_running", int'(running), 0);
    check("async_dead", int'(dead), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // dut_b: start at x=1, go left into the wall
    @(negedge clk);
    q = cyc;
    b_enable = 1'b1;
    push_b(q + 5, 0, 15, 2);
    wait_until(q + 8);
    check("b_pre_dead", int'(b_dead), 0);
    check("b_pre_running", int'(b_running), 1);
    wait_until(q + 9);
    check("b_dead", int'(b_dead), 1);
    check("b_dead_x", int'(b_head_x), 0);
    check("b_dead_dir", int'(b_move_dir), 2);
    check("b_dead_running", int'(b_running), 0);
    wait_until(q + 17);
    check("b_frozen_x", int'(b_head_x), 0);
    check("b_frozen_dead", int'(b_dead), 1);
    b_restart = 1'b1; b_enable = 1'b0;
    @(negedge clk);
    b_restart = 1'b0;
    check("b_rs_x", int'(b_head_x), 1);
    check("b_rs_y", int'(b_head_y), 15);
    check("b_rs_dir", int'(b_move_dir), 4);
    check("b_rs_dead", int'(b_dead), 0);
    check("b_rs_running", int'(b_running), 0);

    repeat (4) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
